// File: rtl/cu_pkg.sv
// cu_pkg: opcodes, state encoding and datapath select codes shared by the control unit.
package cu_pkg;
    localparam logic [3:0] OP_ALU     = 4'h0;
    localparam logic [3:0] OP_ALU_IMM = 4'h1;
    localparam logic [3:0] OP_LOAD    = 4'h2;
    localparam logic [3:0] OP_STORE   = 4'h3;
    localparam logic [3:0] OP_BR      = 4'h4;
    localparam logic [3:0] OP_BMI     = 4'h5;
    localparam logic [3:0] OP_BPL     = 4'h6;
    localparam logic [3:0] OP_BZ      = 4'h7;
    localparam logic [3:0] OP_MOVE    = 4'h8;
    localparam logic [3:0] OP_CMOV    = 4'h9;
    localparam logic [3:0] OP_BAD     = 4'hA;
    localparam logic [3:0] OP_NOP     = 4'hE;
    localparam logic [3:0] OP_HALT    = 4'hF;

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEM_WAIT  = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALTED    = 3'd5;
    localparam logic [2:0] S_FAULT     = 3'd6;

    typedef enum logic [1:0] {DS_ALU = 2'b00, DS_MEM = 2'b01, DS_CMOV = 2'b10} datasel_e;
    typedef enum logic [2:0] {BR_NONE, BR_BR, BR_BMI, BR_BPL, BR_BZ} branch_e;

    // Branch opcodes 4..7 map onto branch codes 1..4.
    function automatic logic [2:0] branch_code(input logic [3:0] op);
        return 3'(op - 4'd3);
    endfunction
endpackage

// File: rtl/control_unit_mc_if.sv
// control_unit_mc_if: handshake, opcode and strobe bundle between the control unit and the datapath.
interface control_unit_mc_if #(parameter int OP_W = 4, parameter int CNT_W = 16);
    logic            cont, imem_ready, dmem_ready;
    logic [OP_W-1:0] op_code;
    logic            imem_req, ir_load, loadPC, writeReg, MemEn, MemWen, IMMsel, halted, fault;
    logic [1:0]      DataSel;
    logic [2:0]      BRANCH, state_o;
    logic [CNT_W-1:0] instr_count;

    modport slave (
        input  cont, op_code, imem_ready, dmem_ready,
        output imem_req, ir_load, loadPC, writeReg, MemEn, MemWen, IMMsel, DataSel, BRANCH,
               halted, fault, state_o, instr_count
    );
    modport master (
        output cont, op_code, imem_ready, dmem_ready,
        input  imem_req, ir_load, loadPC, writeReg, MemEn, MemWen, IMMsel, DataSel, BRANCH,
               halted, fault, state_o, instr_count
    );
endinterface

// File: rtl/cu_timeout_ctr.sv
// cu_timeout_ctr: counts data-memory wait cycles and flags the last allowed one.
module cu_timeout_ctr #(parameter int MEM_TIMEOUT = 15) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int W = MEM_TIMEOUT < 2 ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT == 0 ? 0 : MEM_TIMEOUT - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + 1'b1;

    assign expire_o = MEM_TIMEOUT != 0 && cnt_q == LAST;
endmodule

// File: rtl/control_unit_mc.sv
// control_unit_mc: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer with memory waits,
// timeout fault, edge-resumed HALT and a retired-instruction counter.
module control_unit_mc
    import cu_pkg::*;
#(
    parameter int OP_W         = 4,
    parameter int CNT_W        = 16,
    parameter int MEM_TIMEOUT  = 15,
    parameter bit TRAP_ILLEGAL = 1
) (
    input logic clk,
    input logic reset,
    control_unit_mc_if.slave bus
);
    logic [2:0]       state_q, state_d;
    logic [OP_W-1:0]  op_q;
    logic             cont_q;
    logic [CNT_W-1:0] count_q;
    logic [3:0]       op;
    logic             is_mem, is_store, in_wait, expire;

    // Any set bit above the 4-bit opcode space makes the opcode illegal.
    assign op       = |(op_q >> 4) ? OP_BAD : op_q[3:0];
    assign is_store = op == OP_STORE;
    assign is_mem   = op == OP_LOAD || is_store;
    assign in_wait  = state_q == S_MEM_WAIT;

    cu_timeout_ctr #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
        .clk(clk),
        .reset(reset),
        .clr_i(!in_wait || bus.dmem_ready),
        .en_i(in_wait),
        .expire_o(expire)
    );

    always_comb begin
        state_d      = state_q;
        bus.imem_req = 1'b0;
        bus.ir_load  = 1'b0;
        bus.loadPC   = 1'b0;
        bus.writeReg = 1'b0;
        bus.MemEn    = 1'b0;
        bus.MemWen   = 1'b0;
        bus.IMMsel   = 1'b0;
        bus.DataSel  = DS_ALU;
        bus.BRANCH   = BR_NONE;
        bus.halted   = 1'b0;
        bus.fault    = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.imem_req = 1'b1;
                bus.ir_load  = bus.imem_ready;
                state_d      = bus.imem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                state_d    = S_FETCH;
                bus.loadPC = 1'b1;
                case (op)
                    OP_ALU, OP_ALU_IMM, OP_MOVE, OP_CMOV: begin
                        bus.writeReg = 1'b1;
                        bus.IMMsel   = op == OP_ALU_IMM;
                        bus.DataSel  = op == OP_CMOV ? DS_CMOV : DS_ALU;
                    end
                    OP_BR, OP_BMI, OP_BPL, OP_BZ: begin
                        bus.IMMsel = 1'b1;
                        bus.BRANCH = branch_code(op);
                    end
                    OP_HALT: begin
                        bus.loadPC = 1'b0;
                        state_d    = S_HALTED;
                    end
                    OP_LOAD, OP_STORE, OP_NOP: ;
                    default: if (TRAP_ILLEGAL) begin
                        bus.loadPC = 1'b0;
                        state_d    = S_FAULT;
                    end
                endcase
            end
            S_MEM_WAIT: ;
            S_WRITEBACK: begin
                bus.writeReg = 1'b1;
                bus.DataSel  = DS_MEM;
                bus.loadPC   = 1'b1;
                state_d      = S_FETCH;
            end
            S_HALTED: begin
                bus.halted = 1'b1;
                bus.loadPC = bus.cont & ~cont_q;
                state_d    = bus.cont & ~cont_q ? S_FETCH : S_HALTED;
            end
            S_FAULT: bus.fault = 1'b1;
            default: state_d = S_FAULT;
        endcase
        // Memory access looks identical whether issued in EXECUTE or still waiting.
        if ((state_q == S_EXECUTE || in_wait) && is_mem) begin
            bus.MemEn  = 1'b1;
            bus.MemWen = is_store;
            bus.IMMsel = 1'b1;
            bus.loadPC = bus.dmem_ready && is_store;
            state_d    = bus.dmem_ready ? (is_store ? S_FETCH : S_WRITEBACK)
                                        : (in_wait && expire ? S_FAULT : S_MEM_WAIT);
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= OP_W'(OP_NOP);
            cont_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cont_q  <= bus.cont;
            if (state_q == S_DECODE) op_q <= bus.op_code;
            count_q <= count_q + CNT_W'(bus.loadPC);
        end

    assign bus.state_o     = state_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_control_unit_mc.sv
// tb_control_unit_mc: builds per-instruction expected cycle traces and checks two configured control units.
module tb_control_unit_mc;
    import cu_pkg::*;

    typedef struct {
        logic        ir, dr, ct;
        logic [3:0]  op;
        logic [16:0] ex;
        logic [15:0] cnt;
    } step_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        ir_v[2], dr_v[2], ct_v[2];
    logic [3:0]  op_v[2];
    logic [16:0] obs[2];
    logic [15:0] cnt[2];

    int checks = 0, errors = 0;
    int cnt_m[2];
    step_t q[$];
    logic [16:0] obs_q[$];
    logic [15:0] cnt_q[$];
    logic [15:0] cnt_end;

    control_unit_mc_if #(.OP_W(4), .CNT_W(16)) ifa ();
    control_unit_mc_if #(.OP_W(4), .CNT_W(4))  ifb ();

    control_unit_mc #(.OP_W(4), .CNT_W(16), .MEM_TIMEOUT(4), .TRAP_ILLEGAL(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    control_unit_mc #(.OP_W(4), .CNT_W(4), .MEM_TIMEOUT(0), .TRAP_ILLEGAL(0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));

    assign ifa.cont = ct_v[0];
    assign ifa.imem_ready = ir_v[0];
    assign ifa.dmem_ready = dr_v[0];
    assign ifa.op_code = op_v[0];
    assign ifb.cont = ct_v[1];
    assign ifb.imem_ready = ir_v[1];
    assign ifb.dmem_ready = dr_v[1];
    assign ifb.op_code = op_v[1];
    assign obs[0] = {ifa.imem_req, ifa.ir_load, ifa.loadPC, ifa.writeReg, ifa.MemEn, ifa.MemWen,
                     ifa.IMMsel, ifa.DataSel, ifa.BRANCH, ifa.halted, ifa.fault, ifa.state_o};
    assign obs[1] = {ifb.imem_req, ifb.ir_load, ifb.loadPC, ifb.writeReg, ifb.MemEn, ifb.MemWen,
                     ifb.IMMsel, ifb.DataSel, ifb.BRANCH, ifb.halted, ifb.fault, ifb.state_o};
    assign cnt[0] = ifa.instr_count;
    assign cnt[1] = {12'd0, ifb.instr_count};

    function automatic logic [16:0] ex(input int imr, irl, lpc, wr, me, mw, ims, ds, br, h, f, st);
        return {1'(imr), 1'(irl), 1'(lpc), 1'(wr), 1'(me), 1'(mw), 1'(ims), 2'(ds), 3'(br),
                1'(h), 1'(f), 3'(st)};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom);
    endfunction

    task automatic push(input int sel, input logic ir, dr, ct, input logic [3:0] op, input logic [16:0] e);
        step_t s;
        s.ir = ir; s.dr = dr; s.ct = ct; s.op = op; s.ex = e; s.cnt = 16'(cnt_m[sel]);
        q.push_back(s);
        if (e[14]) cnt_m[sel] = (cnt_m[sel] + 1) % (sel == 0 ? 65536 : 16);
    endtask

    task automatic fault_tail(input int sel);
        repeat (3) push(sel, rb(), rb(), rb(), rop(), ex(0,0,0,0,0,0,0,0,0,0,1,6));
    endtask

    // Expected trace of one instruction from its first FETCH cycle; fs fetch stalls,
    // ms data-memory not-ready cycles, cp = cont level while approaching HALT, hh halt hold cycles.
    task automatic add_instr(input int sel, input logic [3:0] op, input int fs, ms, input logic cp, input int hh);
        logic hlt, st, trap, rdy;
        int to, w;
        hlt  = op == OP_HALT;
        st   = op == OP_STORE;
        trap = sel == 0;
        to   = sel == 0 ? 4 : 0;
        repeat (fs) push(sel, 1'b0, rb(), hlt ? cp : rb(), rop(), ex(1,0,0,0,0,0,0,0,0,0,0,0));
        push(sel, 1'b1, rb(), hlt ? cp : rb(), rop(), ex(1,1,0,0,0,0,0,0,0,0,0,0));
        push(sel, rb(), rb(), hlt ? cp : rb(), op, ex(0,0,0,0,0,0,0,0,0,0,0,1));
        if (op inside {OP_ALU, OP_ALU_IMM, OP_MOVE, OP_CMOV})
            push(sel, rb(), rb(), rb(), rop(),
                 ex(0,0,1,1,0,0,op == OP_ALU_IMM, op == OP_CMOV ? 2 : 0, 0,0,0,2));
        else if (op inside {[OP_BR:OP_BZ]})
            push(sel, rb(), rb(), rb(), rop(), ex(0,0,1,0,0,0,1,0,int'(op) - 3,0,0,2));
        else if (op == OP_NOP || (op inside {[4'hA:4'hD]} && !trap))
            push(sel, rb(), rb(), rb(), rop(), ex(0,0,1,0,0,0,0,0,0,0,0,2));
        else if (op inside {[4'hA:4'hD]}) begin
            push(sel, rb(), rb(), rb(), rop(), ex(0,0,0,0,0,0,0,0,0,0,0,2));
            fault_tail(sel);
        end else if (hlt) begin
            push(sel, rb(), rb(), cp, rop(), ex(0,0,0,0,0,0,0,0,0,0,0,2));
            repeat (hh) push(sel, rb(), rb(), cp, rop(), ex(0,0,0,0,0,0,0,0,0,1,0,5));
            if (cp) push(sel, rb(), rb(), 1'b0, rop(), ex(0,0,0,0,0,0,0,0,0,1,0,5));
            push(sel, rb(), rb(), 1'b1, rop(), ex(0,0,1,0,0,0,0,0,0,1,0,5));
        end else begin
            w = (to != 0 && ms > to) ? to : ms;
            for (int j = 0; j <= w; j++) begin
                rdy = j == ms;
                push(sel, rb(), rdy, rb(), rop(), ex(0,0,rdy && st,0,1,st,1,0,0,0,0, j == 0 ? 2 : 3));
            end
            if (w < ms) fault_tail(sel);
            else if (!st) push(sel, rb(), rb(), rb(), rop(), ex(0,0,1,1,0,0,0,1,0,0,0,4));
        end
    endtask

    task automatic idle(input int sel);
        ir_v[sel] = 1'b0; dr_v[sel] = 1'b0; ct_v[sel] = 1'b0; op_v[sel] = 4'h0;
    endtask

    task automatic play(input int sel);
        obs_q.delete();
        cnt_q.delete();
        foreach (q[i]) begin
            @(negedge clk);
            ir_v[sel] = q[i].ir; dr_v[sel] = q[i].dr; ct_v[sel] = q[i].ct; op_v[sel] = q[i].op;
            #1;
            obs_q.push_back(obs[sel]);
            cnt_q.push_back(cnt[sel]);
        end
        @(negedge clk);
        idle(sel);
        #1 cnt_end = cnt[sel];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(0);
        idle(1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(0);
        idle(1);
        for (int r = 0; r < 2; r++) begin
            #1;
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs[s] !== ex(1,0,0,0,0,0,0,0,0,0,0,0)) begin
                    errors++;
                    $display("FAIL reset_outputs dut%0d got %h want %h", s, obs[s], ex(1,0,0,0,0,0,0,0,0,0,0,0));
                end
                checks++;
                if (cnt[s] !== 16'd0) begin
                    errors++;
                    $display("FAIL reset_count dut%0d got %0d want 0", s, cnt[s]);
                end
            end
            @(negedge clk);
        end
        reset = 1'b0;
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        q.delete();
    endtask

    task automatic test_fetch_stall();
        q.delete();
        add_instr(0, OP_ALU_IMM, 2, 0, 1'b0, 1);
        play(0);
        foreach (q[i]) begin
            checks++;
            if ({obs_q[i], cnt_q[i]} !== {q[i].ex, q[i].cnt}) begin
                errors++;
                $display("FAIL fetch_stall cyc %0d got %h/%0d want %h/%0d", i, obs_q[i], cnt_q[i], q[i].ex, q[i].cnt);
            end
        end
        checks++;
        if (cnt_end !== 16'd1) begin
            errors++;
            $display("FAIL fetch_stall_count got %0d want 1", cnt_end);
        end
    endtask

    task automatic test_load_wait();
        q.delete();
        add_instr(0, OP_LOAD, 0, 3, 1'b0, 1);
        add_instr(0, OP_LOAD, 1, 0, 1'b0, 1);
        play(0);
        foreach (q[i]) begin
            checks++;
            if ({obs_q[i], cnt_q[i]} !== {q[i].ex, q[i].cnt}) begin
                errors++;
                $display("FAIL load_wait cyc %0d got %h/%0d want %h/%0d", i, obs_q[i], cnt_q[i], q[i].ex, q[i].cnt);
            end
        end
        checks++;
        if (cnt_end !== 16'(cnt_m[0])) begin
            errors++;
            $display("FAIL load_wait_count got %0d want %0d", cnt_end, cnt_m[0]);
        end
    endtask

    task automatic test_store_timeout();
        q.delete();
        add_instr(0, OP_STORE, 0, 4, 1'b0, 1);
        add_instr(0, OP_STORE, 0, 0, 1'b0, 1);
        add_instr(0, OP_STORE, 1, 9, 1'b0, 1);
        play(0);
        foreach (q[i]) begin
            checks++;
            if ({obs_q[i], cnt_q[i]} !== {q[i].ex, q[i].cnt}) begin
                errors++;
                $display("FAIL store_timeout cyc %0d got %h/%0d want %h/%0d", i, obs_q[i], cnt_q[i], q[i].ex, q[i].cnt);
            end
        end
        checks++;
        if (obs[0] !== ex(0,0,0,0,0,0,0,0,0,0,1,6)) begin
            errors++;
            $display("FAIL fault_sticky got %h want %h", obs[0], ex(0,0,0,0,0,0,0,0,0,0,1,6));
        end
        do_reset();
    endtask

    task automatic test_halt();
        q.delete();
        add_instr(0, OP_HALT, 1, 0, 1'b1, 3);
        add_instr(0, OP_HALT, 0, 0, 1'b0, 2);
        add_instr(0, OP_NOP, 0, 0, 1'b0, 1);
        play(0);
        foreach (q[i]) begin
            checks++;
            if ({obs_q[i], cnt_q[i]} !== {q[i].ex, q[i].cnt}) begin
                errors++;
                $display("FAIL halt cyc %0d got %h/%0d want %h/%0d", i, obs_q[i], cnt_q[i], q[i].ex, q[i].cnt);
            end
        end
        checks++;
        if (cnt_end !== 16'd3) begin
            errors++;
            $display("FAIL halt_count got %0d want 3", cnt_end);
        end
    endtask

    task automatic test_illegal();
        q.delete();
        add_instr(0, 4'hA, 0, 0, 1'b0, 1);
        play(0);
        foreach (q[i]) begin
            checks++;
            if ({obs_q[i], cnt_q[i]} !== {q[i].ex, q[i].cnt}) begin
                errors++;
                $display("FAIL illegal_trap cyc %0d got %h/%0d want %h/%0d", i, obs_q[i], cnt_q[i], q[i].ex, q[i].cnt);
            end
        end
        do_reset();
        for (int o = 10; o < 14; o++) add_instr(1, 4'(o), 0, 0, 1'b0, 1);
        play(1);
        foreach (q[i]) begin
            checks++;
            if ({obs_q[i], cnt_q[i]} !== {q[i].ex, q[i].cnt}) begin
                errors++;
                $display("FAIL illegal_nop cyc %0d got %h/%0d want %h/%0d", i, obs_q[i], cnt_q[i], q[i].ex, q[i].cnt);
            end
        end
        checks++;
        if (cnt_end !== 16'd4) begin
            errors++;
            $display("FAIL illegal_nop_count got %0d want 4", cnt_end);
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int s = 0; s < 2; s++) begin
            q.delete();
            for (int n = 0; n < 60; n++) begin
                op = rop();
                while (s == 0 && op inside {[4'hA:4'hD]}) op = rop();
                add_instr(s, op, $urandom_range(3), $urandom_range(s == 0 ? 4 : 8), rb(), 1 + $urandom_range(2));
            end
            play(s);
            foreach (q[i]) begin
                checks++;
                if ({obs_q[i], cnt_q[i]} !== {q[i].ex, q[i].cnt}) begin
                    errors++;
                    $display("FAIL random dut%0d cyc %0d got %h/%0d want %h/%0d", s, i, obs_q[i], cnt_q[i], q[i].ex, q[i].cnt);
                end
            end
            checks++;
            if (cnt_end !== 16'(cnt_m[s])) begin
                errors++;
                $display("FAIL random_count dut%0d got %0d want %0d", s, cnt_end, cnt_m[s]);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        q.delete();
        push(0, 1'b1, 1'b0, 1'b0, 4'h0, ex(1,1,0,0,0,0,0,0,0,0,0,0));
        push(0, 1'b0, 1'b0, 1'b0, OP_STORE, ex(0,0,0,0,0,0,0,0,0,0,0,1));
        push(0, 1'b0, 1'b0, 1'b0, 4'h0, ex(0,0,0,0,1,1,1,0,0,0,0,2));
        push(0, 1'b0, 1'b0, 1'b0, 4'h0, ex(0,0,0,0,1,1,1,0,0,0,0,3));
        play(0);
        foreach (q[i]) begin
            checks++;
            if ({obs_q[i], cnt_q[i]} !== {q[i].ex, q[i].cnt}) begin
                errors++;
                $display("FAIL mid_wait cyc %0d got %h/%0d want %h/%0d", i, obs_q[i], cnt_q[i], q[i].ex, q[i].cnt);
            end
        end
        @(negedge clk);
        idle(0);
        #1;
        checks++;
        if (obs[0] !== ex(0,0,0,0,1,1,1,0,0,0,0,3)) begin
            errors++;
            $display("FAIL mid_wait_hold got %h want %h", obs[0], ex(0,0,0,0,1,1,1,0,0,0,0,3));
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs[0] !== ex(1,0,0,0,0,0,0,0,0,0,0,0)) begin
            errors++;
            $display("FAIL async_reset_outputs got %h want %h", obs[0], ex(1,0,0,0,0,0,0,0,0,0,0,0));
        end
        checks++;
        if (cnt[0] !== 16'd0) begin
            errors++;
            $display("FAIL async_reset_count got %0d want 0", cnt[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        cnt_m[0] = 0;
        cnt_m[1] = 0;
    endtask

    initial begin
        idle(0);
        idle(1);
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        test_reset();
        test_fetch_stall();
        test_load_wait();
        test_store_timeout();
        test_halt();
        test_illegal();
        test_random();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_unit_mc.md
Name: control_unit_mc

Overview:
Parametrised multi-cycle control FSM, the successor to the fast control unit. Sequences FETCH/DECODE/EXECUTE/WRITEBACK like its predecessor and adds:
- ready/wait handshakes on instruction and data memory
- a registered opcode, so outputs are fully defined in every state (no inferred latches)
- a data-memory timeout fault
- edge-triggered resume from HALT
- a retired-instruction counter

Sits between the instruction register/decoder and the datapath muxes, PC, register file and memories.

Parameters:
OP_W, 4, opcode width; opcodes are zero-extended constants.
CNT_W, 16, width of instr_count.
MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before FAULT; 0 disables the timeout.
TRAP_ILLEGAL, 1, 1 = undefined opcode goes to FAULT; 0 = treated as NOP.

Ports:
clk  in  1  clock
reset  in  1  reset
cont  in  1  resume request for HALTED; rising edge is used
op_code  in  OP_W  opcode from IR, valid in DECODE
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
ir_load  out  1  load IR
loadPC  out  1  PC update strobe
writeReg  out  1  register file write enable
MemEn  out  1  data memory enable
MemWen  out  1  data memory write enable
IMMsel  out  1  0 = RS2, 1 = immediate
DataSel  out  2  00 ALU/MOVE, 01 memory, 10 CMOV
BRANCH  out  3  000 none, 001 BR, 010 BMI, 011 BPL, 100 BZ
halted  out  1  in HALTED
fault  out  1  in FAULT (sticky)
state_o  out  3  current state encoding (debug)
instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset: asynchronous, active-high; clock clk; all flops reset asynchronously.
  - state=FETCH, op_q=NOP, wait_cnt=0, cont_q=0, instr_count=0.
  - Outputs are combinational from state/op_q; during reset all strobes are 0 except imem_req=1 (FETCH); DataSel=00, BRANCH=000.
- Opcodes: ALU=0, ALU_IMM=1, LOAD=2, STORE=3, BR=4, BMI=5, BPL=6, BZ=7, MOVE=8, CMOV=9, NOP=E, HALT=F; all others are illegal.
- Output defaults: every output is 0 in every state unless listed below.
- States: FETCH(0), DECODE(1), EXECUTE(2), MEM_WAIT(3), WRITEBACK(4), HALTED(5), FAULT(6).
- FETCH:
  - imem_req=1; ir_load=imem_ready.
  - Go to DECODE when imem_ready, else stay.
- DECODE: op_q<=op_code; go to EXECUTE. Always 1 cycle.
- EXECUTE, decoded from op_q:
  - ALU: writeReg=1, loadPC=1, IMMsel=0 -> FETCH.
  - ALU_IMM: as ALU with IMMsel=1.
  - MOVE: writeReg=1, loadPC=1, DataSel=00 -> FETCH.
  - CMOV: DataSel=10, writeReg=1, loadPC=1 -> FETCH.
  - Branches: IMMsel=1, BRANCH=code, loadPC=1 -> FETCH.
  - NOP, or illegal with TRAP_ILLEGAL=0: loadPC=1 -> FETCH.
  - Illegal with TRAP_ILLEGAL=1: no strobes -> FAULT.
  - LOAD/STORE: MemEn=1, IMMsel=1, MemWen=(STORE).
    - If dmem_ready: LOAD -> WRITEBACK; STORE asserts loadPC=1 -> FETCH.
    - If not dmem_ready: -> MEM_WAIT.
  - HALT: no strobes -> HALTED.
- MEM_WAIT:
  - Holds MemEn/MemWen/IMMsel exactly as in EXECUTE; wait_cnt increments each cycle.
  - On dmem_ready: exit exactly as in EXECUTE; wait_cnt<=0.
  - If MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT-1 without ready: -> FAULT. dmem_ready in that same cycle wins over the timeout.
- WRITEBACK: writeReg=1, DataSel=01, loadPC=1 -> FETCH.
- HALTED:
  - halted=1; cont_q<=cont every cycle, in all states.
  - On cont & ~cont_q: loadPC=1 -> FETCH.
  - cont held high on entry does not resume; it must fall, then rise again.
- FAULT: fault=1, all strobes 0; leaves only on reset.
- instr_count increments on every cycle with loadPC=1 and wraps mod 2^CNT_W.
- Async reset mid-MEM_WAIT or mid-HALT drops all strobes immediately and returns to FETCH.

Decomposition:
- Shared package cu_pkg:
  - opcode constants
  - state encoding
  - DataSel codes and BRANCH codes
- One sub-module, cu_timeout_ctr: a wait counter with clear, enable and expire outputs, parametrised by MEM_TIMEOUT.

Test Plan:
1. ALU_IMM with imem_ready stalled 2 cycles -> FETCH lasts 3 cycles. EXECUTE asserts writeReg=1, IMMsel=1, loadPC=1. instr_count 0->1. Total 5 cycles.
2. LOAD with dmem_ready low 3 cycles -> MemEn=1, MemWen=0 held for 4 cycles, then WRITEBACK with DataSel=01, writeReg=1, loadPC=1.
3. STORE with MEM_TIMEOUT=4 and dmem_ready never high -> 4 MEM_WAIT cycles, then fault=1, state_o=6 sticky. Variant with ready on the 4th MEM_WAIT cycle -> no fault.
4. HALT with cont already high -> halted=1 and stays. cont low then high -> one-cycle loadPC, back in FETCH, count +1.
5. op_code=A: TRAP_ILLEGAL=1 -> FAULT; TRAP_ILLEGAL=0 -> behaves as NOP (loadPC only).
6. Assert reset during MEM_WAIT of a STORE -> MemEn/MemWen=0 within the same cycle, state_o=0, instr_count=0.
